// File: rtl/sprite_compositor.sv
// sprite_compositor: N-layer sprite priority compositor with a two-stage
// pipeline. Configuration is shadowed on frame_start so that a frame is
// always composited with one consistent set of settings.
// Optional feature macro: SPRITE_COLLISION_EN adds collision_flag and
// collision_count outputs (sticky per-frame collision detection).
module sprite_compositor #(
  parameter int N  = 4,
  parameter int CW = 12,
  localparam int B = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            frame_start,
  input  logic            de_in,
  input  logic            hs_in,
  input  logic            vs_in,
  input  logic [N*CW-1:0] layer_px,
  input  logic [N-1:0]    cfg_en_mask,
  input  logic [CW-1:0]   cfg_key,
  input  logic [CW-1:0]   cfg_bg,
  input  logic [B-1:0]    cfg_top,
  output logic [CW-1:0]   colour_data,
  output logic            de_out,
  output logic            hs_out,
  output logic            vs_out,
  output logic [B-1:0]    hit_layer,
  output logic            hit_valid
`ifdef SPRITE_COLLISION_EN
  ,
  output logic            collision_flag,
  output logic [15:0]     collision_count
`endif
);

  // N expressed in B+1 bits so index arithmetic stays width-consistent
  localparam logic [B:0] NB = (B+1)'(N);

  // Reduce a top index into 0..N-1; inputs are below 2*N so one subtract suffices
  function automatic logic [B-1:0] f_wrap_top(input logic [B-1:0] t);
    logic [B:0] v;
    v = {1'b0, t};
    if (v >= NB) begin
      v = v - NB;
    end else begin
      v = v;
    end
    return v[B-1:0];
  endfunction

  // True when two or more bits of the opaque mask are set
  function automatic logic f_multi(input logic [N-1:0] m);
    int cnt;
    cnt = 0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + int'(m[i]);
    end
    return (cnt >= 2) ? 1'b1 : 1'b0;
  endfunction

  // Shadow configuration
  logic [N-1:0]    r_sh_mask;
  logic [CW-1:0]   r_sh_key;
  logic [CW-1:0]   r_sh_bg;
  logic [B-1:0]    r_sh_top;

  // Stage 1
  logic [N-1:0]    r_s1_opaque;
  logic [N*CW-1:0] r_s1_px;
  logic            r_s1_de;
  logic            r_s1_hs;
  logic            r_s1_vs;
  logic [B-1:0]    r_s1_top;
  logic [CW-1:0]   r_s1_bg;

  // Stage 2
  logic [CW-1:0]   r_s2_colour;
  logic [B-1:0]    r_s2_layer;
  logic            r_s2_valid;
  logic            r_s2_de;
  logic            r_s2_hs;
  logic            r_s2_vs;

  logic [N-1:0]    w_opaque;
  logic            w_found;
  logic [B-1:0]    w_win_idx;
  logic [CW-1:0]   w_win_col;

  // Shadow load on frame_start; the pixel on this edge still sees the old values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_mask <= '0;
      r_sh_key  <= '0;
      r_sh_bg   <= '0;
      r_sh_top  <= '0;
    end else if (frame_start) begin
      r_sh_mask <= cfg_en_mask;
      r_sh_key  <= cfg_key;
      r_sh_bg   <= cfg_bg;
      r_sh_top  <= f_wrap_top(cfg_top);
    end else begin
      r_sh_mask <= r_sh_mask;
      r_sh_key  <= r_sh_key;
      r_sh_bg   <= r_sh_bg;
      r_sh_top  <= r_sh_top;
    end
  end

  // A layer is opaque when enabled and its colour differs from the key
  always_comb begin
    w_opaque = '0;
    for (int i = 0; i < N; i++) begin
      w_opaque[i] = r_sh_mask[i] && (layer_px[i*CW +: CW] != r_sh_key);
    end
  end

  // Stage 1: register opaque mask, colours, sideband and the config used for them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_opaque <= '0;
      r_s1_px     <= '0;
      r_s1_de     <= 1'b0;
      r_s1_hs     <= 1'b0;
      r_s1_vs     <= 1'b0;
      r_s1_top    <= '0;
      r_s1_bg     <= '0;
    end else begin
      r_s1_opaque <= w_opaque;
      r_s1_px     <= layer_px;
      r_s1_de     <= de_in;
      r_s1_hs     <= hs_in;
      r_s1_vs     <= vs_in;
      r_s1_top    <= r_sh_top;
      r_s1_bg     <= r_sh_bg;
    end
  end

  // Rotating priority search: first opaque layer starting from top wins
  always_comb begin
    logic [B:0]   sum;
    logic [B-1:0] idx;
    w_found   = 1'b0;
    w_win_idx = '0;
    w_win_col = r_s1_bg;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, r_s1_top} + (B+1)'(k);
      if (sum >= NB) begin
        sum = sum - NB;
      end else begin
        sum = sum;
      end
      idx = sum[B-1:0];
      if (!w_found && r_s1_opaque[idx]) begin
        w_found   = 1'b1;
        w_win_idx = idx;
        w_win_col = r_s1_px[idx*CW +: CW];
      end else begin
        w_found   = w_found;
      end
    end
  end

  // Stage 2: register composited pixel; blanking forces all-zero output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_colour <= '0;
      r_s2_layer  <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_de     <= 1'b0;
      r_s2_hs     <= 1'b0;
      r_s2_vs     <= 1'b0;
    end else begin
      r_s2_de <= r_s1_de;
      r_s2_hs <= r_s1_hs;
      r_s2_vs <= r_s1_vs;
      if (r_s1_de) begin
        r_s2_colour <= w_win_col;
        r_s2_layer  <= w_found ? w_win_idx : '0;
        r_s2_valid  <= w_found;
      end else begin
        r_s2_colour <= '0;
        r_s2_layer  <= '0;
        r_s2_valid  <= 1'b0;
      end
    end
  end

  assign colour_data = r_s2_colour;
  assign hit_layer   = r_s2_layer;
  assign hit_valid   = r_s2_valid;
  assign de_out      = r_s2_de;
  assign hs_out      = r_s2_hs;
  assign vs_out      = r_s2_vs;

`ifdef SPRITE_COLLISION_EN
  logic        r_coll_flag;
  logic [15:0] r_coll_count;

  // Sticky per-frame collision tracking; frame_start clear beats a same-cycle hit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_coll_flag  <= 1'b0;
      r_coll_count <= 16'h0000;
    end else if (frame_start) begin
      r_coll_flag  <= 1'b0;
      r_coll_count <= 16'h0000;
    end else if (r_s1_de && f_multi(r_s1_opaque)) begin
      r_coll_flag  <= 1'b1;
      r_coll_count <= (r_coll_count == 16'hFFFF) ? r_coll_count : r_coll_count + 16'h0001;
    end else begin
      r_coll_flag  <= r_coll_flag;
      r_coll_count <= r_coll_count;
    end
  end

  assign collision_flag  = r_coll_flag;
  assign collision_count = r_coll_count;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed testbench for sprite_compositor (N=4, CW=12). Collision checks are
// compiled in when SPRITE_COLLISION_EN is defined.
module tb_sprite_compositor;

  localparam int N  = 4;
  localparam int CW = 12;
  localparam int B  = 2;

  logic            clk;
  logic            rst_n;
  logic            frame_start;
  logic            de_in;
  logic            hs_in;
  logic            vs_in;
  logic [N*CW-1:0] layer_px;
  logic [N-1:0]    cfg_en_mask;
  logic [CW-1:0]   cfg_key;
  logic [CW-1:0]   cfg_bg;
  logic [B-1:0]    cfg_top;
  logic [CW-1:0]   colour_data;
  logic            de_out;
  logic            hs_out;
  logic            vs_out;
  logic [B-1:0]    hit_layer;
  logic            hit_valid;
`ifdef SPRITE_COLLISION_EN
  logic            collision_flag;
  logic [15:0]     collision_count;
`endif

  int n_checks;
  int n_fail;

  logic [N*CW-1:0] px_a;
  logic [N*CW-1:0] px_b;
  logic [N*CW-1:0] px_key;
  logic [N*CW-1:0] px_one;

  sprite_compositor #(.N(N), .CW(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .de_in       (de_in),
    .hs_in       (hs_in),
    .vs_in       (vs_in),
    .layer_px    (layer_px),
    .cfg_en_mask (cfg_en_mask),
    .cfg_key     (cfg_key),
    .cfg_bg      (cfg_bg),
    .cfg_top     (cfg_top),
    .colour_data (colour_data),
    .de_out      (de_out),
    .hs_out      (hs_out),
    .vs_out      (vs_out),
    .hit_layer   (hit_layer),
    .hit_valid   (hit_valid)
`ifdef SPRITE_COLLISION_EN
    ,
    .collision_flag  (collision_flag),
    .collision_count (collision_count)
`endif
  );

  // 100 MHz pixel clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_px(input string tag, input logic [CW-1:0] col, input logic [B-1:0] lay,
                          input logic val, input logic de);
    check_eq({tag, "_colour"}, 32'(colour_data), 32'(col));
    check_eq({tag, "_layer"},  32'(hit_layer),   32'(lay));
    check_eq({tag, "_valid"},  32'(hit_valid),   32'(val));
    check_eq({tag, "_de"},     32'(de_out),      32'(de));
  endtask

  // One blanking cycle with frame_start loading the given configuration
  task automatic load_cfg(input logic [N-1:0] m, input logic [CW-1:0] k,
                          input logic [CW-1:0] bg, input logic [B-1:0] t);
    cfg_en_mask = m;
    cfg_key     = k;
    cfg_bg      = bg;
    cfg_top     = t;
    de_in       = 1'b0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  // Hold one pixel on the inputs for two cycles so its result reaches the output
  task automatic run_px(input logic [N*CW-1:0] px, input logic de);
    layer_px = px;
    de_in    = de;
    step();
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    px_a   = {12'h00F, 12'h0F0, 12'hF00, 12'h000};
    px_b   = {12'hDDD, 12'hCCC, 12'hBBB, 12'hAAA};
    px_key = {12'h456, 12'h456, 12'h456, 12'h456};
    px_one = {12'h000, 12'h000, 12'hF00, 12'h000};

    rst_n = 1'b0; frame_start = 1'b0; de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
    layer_px = '0; cfg_en_mask = '0; cfg_key = '0; cfg_bg = '0; cfg_top = '0;
    step();
    step();
    check_px("reset", 12'h000, 2'd0, 1'b0, 1'b0);
    check_eq("reset_hs", 32'(hs_out), 32'h0);
    check_eq("reset_vs", 32'(vs_out), 32'h0);
    rst_n = 1'b1;
    step();

    // Basic priority with top=0, plus exact two-cycle latency incl. sideband
    load_cfg(4'b1111, 12'h000, 12'h000, 2'd0);
    layer_px = px_a; de_in = 1'b1; hs_in = 1'b1; vs_in = 1'b1;
    step();
    check_eq("lat1_de", 32'(de_out), 32'h0);
    check_eq("lat1_hs", 32'(hs_out), 32'h0);
    step();
    check_px("top0", 12'hF00, 2'd1, 1'b1, 1'b1);
    check_eq("lat2_hs", 32'(hs_out), 32'h1);
    check_eq("lat2_vs", 32'(vs_out), 32'h1);
    hs_in = 1'b0; vs_in = 1'b0;

    // Pixel on the frame_start edge uses old top; the next pixel uses new top
    cfg_top = 2'd2; frame_start = 1'b1; layer_px = px_a; de_in = 1'b1;
    step();
    frame_start = 1'b0;
    step();
    check_px("fs_edge_old", 12'hF00, 2'd1, 1'b1, 1'b1);
    step();
    check_px("top2", 12'h0F0, 2'd2, 1'b1, 1'b1);

    load_cfg(4'b1111, 12'h000, 12'h000, 2'd3);
    run_px(px_a, 1'b1);
    check_px("top3", 12'h00F, 2'd3, 1'b1, 1'b1);

    // Black layer is opaque when it differs from the key
    load_cfg(4'b1111, 12'hF00, 12'h000, 2'd0);
    run_px(px_a, 1'b1);
    check_px("black_opaque", 12'h000, 2'd0, 1'b1, 1'b1);

    // All layers keyed out: background shows; blanking forces zero
    load_cfg(4'b1111, 12'h456, 12'h123, 2'd0);
    run_px(px_key, 1'b1);
    check_px("bg", 12'h123, 2'd0, 1'b0, 1'b1);
    run_px(px_a, 1'b0);
    check_px("blank", 12'h000, 2'd0, 1'b0, 1'b0);

    // Enable mask with wrap-around priority: order 1,2,3,0 with only 0 and 3 on
    load_cfg(4'b1001, 12'h000, 12'h000, 2'd1);
    run_px(px_b, 1'b1);
    check_px("mask_wrap", 12'hDDD, 2'd3, 1'b1, 1'b1);

    // Config change without frame_start must not take effect
    cfg_en_mask = 4'b1111; cfg_top = 2'd0; cfg_key = 12'hDDD;
    run_px(px_b, 1'b1);
    check_px("no_fs", 12'hDDD, 2'd3, 1'b1, 1'b1);
    load_cfg(4'b1111, 12'h000, 12'h000, 2'd0);
    run_px(px_b, 1'b1);
    check_px("after_fs", 12'hAAA, 2'd0, 1'b1, 1'b1);

    // Mid-line reset: outputs clear at once, shadow cleared, latency restarts
    hs_in = 1'b1; vs_in = 1'b1;
    run_px(px_a, 1'b1);
    rst_n = 1'b0;
    #1;
    check_px("rst_mid", 12'h000, 2'd0, 1'b0, 1'b0);
    check_eq("rst_mid_hs", 32'(hs_out), 32'h0);
    check_eq("rst_mid_vs", 32'(vs_out), 32'h0);
    step();
    rst_n = 1'b1; layer_px = px_a; de_in = 1'b1;
    step();
    check_eq("post_rst_lat1_de", 32'(de_out), 32'h0);
    step();
    check_px("post_rst", 12'h000, 2'd0, 1'b0, 1'b1);
    hs_in = 1'b0; vs_in = 1'b0;

`ifdef SPRITE_COLLISION_EN
    load_cfg(4'b1111, 12'h000, 12'h000, 2'd0);
    check_eq("coll_init_cnt", 32'(collision_count), 32'h0);
    layer_px = px_a; de_in = 1'b1;
    repeat (5) step();
    de_in = 1'b0;
    step();
    step();
    check_eq("coll_flag5", 32'(collision_flag), 32'h1);
    check_eq("coll_cnt5", 32'(collision_count), 32'd5);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check_eq("coll_clr_flag", 32'(collision_flag), 32'h0);
    check_eq("coll_clr_cnt", 32'(collision_count), 32'h0);
    // Clear wins over an increment on the same edge
    layer_px = px_a; de_in = 1'b1;
    step();
    de_in = 1'b0; frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
    step();
    check_eq("coll_prec_flag", 32'(collision_flag), 32'h0);
    check_eq("coll_prec_cnt", 32'(collision_count), 32'h0);
    // Single opaque layer is not a collision
    run_px(px_one, 1'b1);
    step();
    check_eq("coll_single", 32'(collision_flag), 32'h0);
    // Saturation
    layer_px = px_a; de_in = 1'b1;
    repeat (70000) step();
    de_in = 1'b0;
    step();
    step();
    check_eq("coll_sat", 32'(collision_count), 32'hFFFF);
    check_eq("coll_sat_flag", 32'(collision_flag), 32'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_compositor.md
SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 SHALL provide parameter N, default 4, number of sprite layers; legal range 2..8.
REQ-002 SHALL provide parameter CW, default 12, colour width in bits (4:4:4 RGB at default).
REQ-003 SHALL derive local parameter B = $clog2(N), the layer-index width.
REQ-004 SHALL use one clock and an asynchronous active-low reset: clk  in  1  pixel clock, all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 frame_start  in  1  one-cycle pulse, asserted during vertical blanking (de_in=0).
REQ-007 de_in, hs_in, vs_in  in  1 each  display-enable and sync sideband from the timing generator.
REQ-008 layer_px  in  N*CW  layer colours; layer i occupies bits [i*CW +: CW].
REQ-009 cfg_en_mask  in  N  per-layer enable; cfg_key  in  CW  transparency key colour.
REQ-010 cfg_bg  in  CW  background colour; cfg_top  in  B  highest-priority layer index.
REQ-011 colour_data  out  CW  composited pixel; de_out, hs_out, vs_out  out  1 each  delayed sideband.
REQ-012 hit_layer  out  B  winning layer index; hit_valid  out  1  a layer (not background) won.

Function
REQ-013 SHALL capture cfg_en_mask, cfg_key, cfg_bg and cfg_top into shadow registers on every clock edge where frame_start=1; all compositing SHALL use only shadow values.
REQ-014 The pixel sampled on a frame_start edge SHALL use the pre-load shadow values.
REQ-015 Layer i SHALL be opaque when shadow enable bit i=1 and its colour != shadow key.
REQ-016 Priority order SHALL be (top+k) mod N for k=0..N-1; the first opaque layer in that order SHALL win.
REQ-017 cfg_top values >= N SHALL be reduced mod N at shadow load.
REQ-018 No opaque layer with de=1: colour_data = shadow bg, hit_valid=0, hit_layer=0.
REQ-019 de=0: colour_data=0, hit_valid=0, hit_layer=0, regardless of layers.
REQ-020 Pipeline SHALL be two registered stages: stage 1 registers the opaque mask, layer colours and sideband; stage 2 registers the priority-encode result.
REQ-021 Latency SHALL be exactly 2 cycles from inputs to colour_data/hit_*; de_out/hs_out/vs_out SHALL be delayed by the same 2 cycles.
REQ-022 The block SHALL accept one pixel per clock with no stalls and no back-pressure.

Reset
REQ-023 While rst_n=0: colour_data=0, hit_layer=0, hit_valid=0, de_out=0, hs_out=0, vs_out=0.
REQ-024 On reset, all pipeline registers SHALL clear; shadow mask=0, key=0, bg=0, top=0.
REQ-025 Reset asserted mid-line SHALL discard in-flight pixels; the first valid output SHALL appear 2 cycles after the first post-release input.

Configuration
REQ-026 Macro SPRITE_COLLISION_EN, when defined, SHALL add outputs collision_flag (1) and collision_count (16).
REQ-027 With SPRITE_COLLISION_EN, collision_flag SHALL set, aligned with stage-2 output, when de=1 and at least 2 layers are opaque; it SHALL be sticky until the next frame_start.
REQ-028 collision_count SHALL increment once per colliding pixel and saturate at 16'hFFFF.
REQ-029 frame_start SHALL clear collision_flag and collision_count; clear SHALL take precedence over a same-cycle set or increment; both SHALL reset to 0.
REQ-030 Without SPRITE_COLLISION_EN, the collision ports and logic SHALL be absent, with no other behavioural change.

Verification
REQ-031 N=4, mask=4'b1111, key=0, top=0; layers {0x000,0xF00,0x0F0,0x00F}, de=1 -> 2 cycles later colour_data=0xF00, hit_layer=1, hit_valid=1.
REQ-032 Same pixel with top=2 loaded via frame_start -> colour_data=0x0F0, hit_layer=2; top=3 -> 0x00F, hit_layer=3.
REQ-033 All layers equal the key, bg=0x123, de=1 -> colour_data=0x123, hit_valid=0; de=0 -> colour_data=0.
REQ-034 Change cfg_* mid-frame without frame_start -> output unchanged; after a frame_start pulse, the new config applies from the next pixel.
REQ-035 Collision build: 3 opaque layers for 5 pixels -> collision_flag=1, collision_count=5; frame_start -> both 0; 70000 colliding pixels -> count=0xFFFF.
REQ-036 rst_n pulsed low mid-line -> all outputs 0 immediately; first output valid exactly 2 cycles after the first post-release pixel.
